// File: rtl/sap_pkg.sv
// Shared types and widths for the SAP RAM dump path.
package sap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP,
    FIN
  } state_t;

  localparam int RAM_AW         = 4;
  localparam int DATA_W         = 8;
  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_core.sv
// UART 8N1 transmitter: byte-in valid/ready handshake, owns baud timing and START/DATA/STOP.
module uart_tx_core
  import sap_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              frame_end,
  output logic              tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

  state_t            state;
  logic [CW-1:0]     baud_cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              baud_end;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign ready     = (state == IDLE);
  // Combinational so the sequencer can leave its frame state on the same edge as the stop bit ends.
  assign frame_end = (state == STOP) && baud_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (abort) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          shreg    <= data;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: if (baud_end) begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx       <= shreg[0];
          state    <= DATA;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
        DATA: if (baud_end) begin
          baud_cnt <= '0;
          shreg    <= shreg >> 1;
          if (bit_idx == BIT_LAST) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= shreg[1];
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
        STOP: if (baud_end) begin
          baud_cnt <= '0;
          state    <= IDLE;
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_dump_tx.sv
// Walks the program RAM on a dump request while the CPU is halted and streams each byte over UART.
module ram_dump_tx
  import sap_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_WORDS    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dump_btn,
  output logic [RAM_AW-1:0] rd_addr,
  output logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(NUM_WORDS - 1);

  state_t state;
  logic   dump_btn_q;
  logic   trig;
  logic   tx_valid;
  logic   core_ready;
  logic   frame_end;

  assign trig = dump_btn & ~dump_btn_q;

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .abort     (start),
    .data      (rd_data),
    .valid     (tx_valid),
    .ready     (core_ready),
    .frame_end (frame_end),
    .tx        (tx)
  );

  // rd_addr doubles as the address counter; START stands for the whole frame while the core runs it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dump_btn_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      tx_valid   <= 1'b0;
    end else begin
      dump_btn_q <= dump_btn;
      done       <= 1'b0;
      if (start && state != IDLE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        rd_req   <= 1'b0;
        rd_addr  <= '0;
        tx_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (trig && !start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            rd_req  <= 1'b1;
            rd_addr <= '0;
          end
          FETCH: begin
            state    <= LOAD;
            tx_valid <= 1'b1;
          end
          LOAD: if (core_ready) begin
            state    <= START;
            rd_req   <= 1'b0;
            tx_valid <= 1'b0;
          end
          START: if (frame_end) begin
            if (rd_addr == LAST_ADDR) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= FETCH;
              rd_addr <= rd_addr + 1'b1;
              rd_req  <= 1'b1;
            end
          end
          FIN: begin
            state   <= IDLE;
            rd_addr <= '0;
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            rd_req  <= 1'b0;
            rd_addr <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_dump_tx.sv
// Directed bench for ram_dump_tx with a RAM model and a UART frame decoder.
module tb_ram_dump_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dump_btn = 1'b0;
  logic [3:0] rd_addr;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] mem [16];
  assign rd_data = mem[rd_addr];

  ram_dump_tx #(.CLKS_PER_BIT(CPB), .NUM_WORDS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dump_btn (dump_btn),
    .rd_addr  (rd_addr),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Frame decoder: bit k of a frame sampled mid-bit at cycle 4k+2 after the falling start edge.
  logic [9:0] frames [$];
  logic       mon_act;
  int         mon_pos;
  logic [9:0] mon_bits;
  logic       mon_clr = 1'b0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (mon_clr || reset) begin
      mon_act <= 1'b0;
      mon_pos <= 0;
      frames.delete();
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act <= 1'b1;
        mon_pos <= 1;
      end
    end else begin
      if (mon_pos % CPB == CPB / 2) mon_bits[mon_pos / CPB] <= tx;
      if (mon_pos == 10 * CPB - 1) begin
        frames.push_back(mon_bits);
        mon_act <= 1'b0;
      end
      mon_pos <= mon_pos + 1;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] mem_val;
    logic [9:0] exp_frame;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int   cyc;
    int   d0;
    int   bad;
    logic hit;
    logic [7:0] b;

    for (int i = 0; i < 16; i++) begin
      b = 8'h10 + 8'(i);
      mem[i] = b;
      tbl[i] = '{b, {1'b1, b, 1'b0}};
    end
    tbl[5] = '{8'hA5, 10'h34A};

    // Reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);

    // Full dump, button held and re-toggled while busy
    clr_mon();
    d0 = done_cnt;
    dump_btn = 1'b1;
    hit = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 1000; c++) begin
      tick(1);
      if (c == 1) begin
        chk("dump_busy_next", busy, 1);
        chk("dump_rd_req", rd_req, 1);
        chk("dump_rd_addr0", rd_addr, 0);
      end
      if (c == 100) dump_btn = 1'b0;
      if (c == 105) dump_btn = 1'b1;
      if (done) begin
        hit = 1'b1;
        cyc = c;
        break;
      end
    end
    chk("done_seen", hit, 1);
    chk("done_cycle", cyc, 673);
    chk("done_busy_low", busy, 0);
    tick(1);
    chk("done_one_cycle", done, 0);
    tick(200);
    chk("done_count", done_cnt - d0, 1);
    chk("no_second_dump", busy, 0);
    chk("frame_count", frames.size(), 16);
    for (int i = 0; i < 16; i++) begin
      b = 8'h10 + 8'(i);
      if (i < frames.size()) chk($sformatf("dump1_frame%0d", i), frames[i], {1'b1, b, 1'b0});
    end

    // Table-driven dump with mem[5]=A5
    for (int i = 0; i < 16; i++) mem[i] = tbl[i].mem_val;
    dump_btn = 1'b0;
    tick(2);
    clr_mon();
    dump_btn = 1'b1;
    hit = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      tick(1);
      if (done) begin
        hit = 1'b1;
        break;
      end
    end
    chk("dump2_done", hit, 1);
    tick(2);
    chk("dump2_frame_count", frames.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < frames.size()) chk($sformatf("tbl_frame%0d", i), frames[i], tbl[i].exp_frame);
    mem[5] = 8'h15;

    // Abort during frame for addr 3, then restart from addr 0
    dump_btn = 1'b0;
    tick(2);
    clr_mon();
    d0 = done_cnt;
    dump_btn = 1'b1;
    hit = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      tick(1);
      if (rd_addr == 4'd3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reach_addr3", hit, 1);
    tick(12);
    start = 1'b1;
    tick(1);
    chk("abort_busy", busy, 0);
    chk("abort_tx", tx, 1);
    chk("abort_rd_req", rd_req, 0);
    chk("abort_rd_addr", rd_addr, 0);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    start = 1'b0;
    dump_btn = 1'b0;
    tick(2);
    clr_mon();
    dump_btn = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick(1);
      if (frames.size() > 0) break;
    end
    chk("restart_frames", frames.size() > 0, 1);
    if (frames.size() > 0) chk("restart_byte0", frames[0][8:1], 8'h10);
    start = 1'b1;
    tick(2);
    start = 1'b0;
    dump_btn = 1'b0;
    tick(2);

    // Request while CPU running is ignored
    start = 1'b1;
    tick(1);
    dump_btn = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      if (busy !== 1'b0 || rd_req !== 1'b0 || tx !== 1'b1) bad++;
    end
    chk("start_high_ignored", bad, 0);
    dump_btn = 1'b0;
    start = 1'b0;
    tick(2);

    // Asynchronous reset mid-frame
    dump_btn = 1'b1;
    tick(20);
    #3 reset = 1'b1;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rd_req", rd_req, 0);
    chk("arst_rd_addr", rd_addr, 0);
    dump_btn = 1'b0;
    tick(1);
    reset = 1'b0;
    chk("arst_tx_next", tx, 1);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("arst_quiet", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ram_dump_tx.md
Name: ram_dump_tx

Overview:
- Reader-side companion to the 16x8 program RAM. Manual programming writes the RAM from switches; this block reads it back.
- On a dump request while the CPU is halted (start low), it walks addresses 0..15, reads each byte through the RAM's combinational read port and transmits it on a UART 8N1 serial line.
- Lets the operator verify a hand-entered program from a host terminal.
- Sits beside the RAM. rd_req drives the RAM address-mux select so rd_addr replaces the CPU address during a dump.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- NUM_WORDS, 16, number of RAM locations dumped; the address width is 4 bits fixed.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  CPU run enable. A dump is accepted only when start=0; start=1 mid-dump aborts.
- dump_btn  input  1  dump request level (already debounced); its rising edge triggers a dump.
- rd_addr  output  4  RAM read address.
- rd_req  output  1  high while the block owns the RAM address mux.
- rd_data  input  8  RAM combinational read data for rd_addr.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from dump acceptance until return to IDLE.
- done  output  1  one-cycle pulse after the final stop bit of address NUM_WORDS-1.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, tx=1, busy=0, done=0, rd_req=0, rd_addr=0.
  - Internal registers cleared: addr counter, bit counter, baud counter, shift register, dump_btn_q.
- Edge detect: dump_btn_q is dump_btn registered. trig = dump_btn & ~dump_btn_q. A trig while busy is ignored.
- State machine (registered, Moore outputs):
  - IDLE: if trig & ~start -> FETCH, addr=0, busy=1. Otherwise stay; busy=0, rd_req=0, tx=1.
  - FETCH: rd_req=1, rd_addr=addr. Takes 1 cycle for RAM data to settle -> LOAD.
  - LOAD: rd_req=1. Captures shreg<=rd_data, clears baud_cnt -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA with bit_idx=0.
  - DATA: tx=shreg[0]. After CLKS_PER_BIT cycles, shift right and increment bit_idx. After bit 7 completes -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then if addr==NUM_WORDS-1 -> FIN; else addr<=addr+1 -> FETCH.
  - FIN: done=1 for exactly one cycle, busy=0 -> IDLE.
- Bit order: LSB first, 8 data bits, no parity, 1 stop bit.
- Frame length: 10*CLKS_PER_BIT cycles of tx activity, plus a 2-cycle FETCH/LOAD gap between frames (tx held high during the gap).
- rd_req: high only in FETCH and LOAD. rd_addr holds addr in all non-IDLE states and returns to 0 in IDLE.
- Data sampling: RAM contents are sampled once per address in LOAD. A RAM write to that address after LOAD does not affect the byte in flight.
- Abort: start=1 in any non-IDLE state -> next cycle IDLE, tx=1, busy=0, rd_req=0, no done pulse. A partially sent frame is truncated; the host sees a framing error, which is accepted.
- Simultaneous trig and start=1 in IDLE: ignored.
- Counter rules:
  - addr increments only in STOP->FETCH and never wraps during a dump.
  - baud_cnt counts 0..CLKS_PER_BIT-1; a bit ends when baud_cnt==CLKS_PER_BIT-1.
  - Counters are sized with $clog2 of their limits.
- Total dump length from trig: 1 + NUM_WORDS*(2+10*CLKS_PER_BIT) cycles to the done pulse.

Decomposition:
- Shared package sap_pkg:
  - state enum (IDLE, FETCH, LOAD, START, DATA, STOP, FIN);
  - RAM_AW=4, DATA_W=8, UART_DATA_BITS=8.
- Sub-module uart_tx_core:
  - byte-in / valid / ready handshake, owns START/DATA/STOP and the baud counter;
  - reusable for future output-register streaming.
- ram_dump_tx keeps the address sequencer, RAM handshake and abort logic.

Test Plan (CLKS_PER_BIT=4, RAM model preloaded mem[i]=8'h10+i):
- Reset mid-frame -> next cycle tx=1, busy=0, rd_req=0, rd_addr=0; tx stays 1 with no further trig.
- dump_btn rising edge with start=0 -> busy=1 next cycle; the UART monitor decodes 16 bytes 0x10..0x1F in order; done pulses once at cycle 1+16*42=673; busy=0 afterwards.
- mem[5]=8'hA5 -> sixth frame bit sequence on tx is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
- start=1 asserted during the frame for addr 3 -> IDLE next cycle, tx=1, no done pulse. A new dump_btn edge with start=0 restarts from addr 0 (first byte 0x10).
- dump_btn held high for the whole dump and toggled again while busy -> exactly one dump; no second start.
- dump_btn edge with start=1 -> no activity: busy=0, rd_req=0, tx=1 for 100 cycles.
